// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish |a| < |b| requests in a single cycle.
module div_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] q_q, q_d;
   logic [XLEN-1:0] r_q, r_d;
   logic [XLEN-1:0] d_q, d_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            rem_q, rem_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;

   logic            sgn, a_neg, b_neg;
   logic            div0, ovf, early;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   shl, trial;
   logic            qbit;
   logic [XLEN-1:0] quo_fin, rem_fin, fin;

   assign sgn   = ~op_i[0];
   assign a_neg = sgn & a_i[XLEN-1];
   assign b_neg = sgn & b_i[XLEN-1];
   assign mag_a = a_neg ? -a_i : a_i;
   assign mag_b = b_neg ? -b_i : b_i;
   assign div0  = (b_i == '0);
   assign ovf   = sgn && (a_i == MIN_NEG) && (b_i == '1);

`ifdef DIV_EARLY_OUT_EN
   assign early = (mag_a < mag_b);
`else
   assign early = 1'b0;
`endif

   // Dividend bits shift out of q_q MSB-first while quotient bits shift in.
   assign shl   = {r_q, q_q[XLEN-1]};
   assign trial = shl - {1'b0, d_q};
   assign qbit  = ~trial[XLEN];

   assign quo_fin = negq_q ? -q_q : q_q;
   assign rem_fin = negr_q ? -r_q : r_q;
   assign fin     = rem_q ? rem_fin : quo_fin;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      res_d   = res_q;
      rem_d   = rem_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               rem_d = op_i[1];
               if (div0 || ovf || early) begin
                  // Special results are stored pre-corrected.
                  state_d = S_DONE;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  d_d     = b_i;
                  cnt_d   = '0;
                  if (div0) begin
                     q_d = '1;
                     r_d = a_i;
                  end else if (ovf) begin
                     q_d = a_i;
                     r_d = '0;
                  end else begin
                     q_d = '0;
                     r_d = a_i;
                  end
               end else begin
                  state_d = S_CALC;
                  q_d     = mag_a;
                  r_d     = '0;
                  d_d     = mag_b;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  cnt_d   = CW'(XLEN-1);
               end
            end
         end
         S_CALC: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               q_d   = {q_q[XLEN-2:0], qbit};
               r_d   = qbit ? trial[XLEN-1:0] : shl[XLEN-1:0];
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!flush_i) res_d = fin;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         res_q   <= '0;
         rem_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         res_q   <= res_d;
         rem_q   <= rem_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

   assign ready_o  = (state_q == S_IDLE);
   assign busy_o   = (state_q == S_CALC);
   assign done_o   = (state_q == S_DONE) && !flush_i;
   assign result_o = done_o ? fin : res_q;

endmodule
